// File: rtl/descrambler_par.sv
// Parallel self-synchronising descrambler for 1 + x^TAP + x^LFSR_W, DATA_W bits per word.
// Tracks fill of the bit history, then flags output words as valid once every tap is real data.
module descrambler_par #(
  parameter int DATA_W = 26,
  parameter int LFSR_W = 58,
  parameter int TAP    = 39,
  parameter int PIPE   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] datain,
  input  logic              datain_valid,
  input  logic              framein,
  input  logic              bypass,
  input  logic              resync,
  output logic [DATA_W-1:0] dataout,
  output logic              dataout_valid,
  output logic              frameout,
  output logic              locked
);

  localparam int EXT_W = LFSR_W + DATA_W;
  localparam int CNT_W = $clog2(EXT_W + 1);
  localparam logic [0:0] S_FILL   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic [LFSR_W-1:0]        r_h;
  logic [CNT_W-1:0]         r_fcnt;
  logic [0:0]               r_state;
  logic [PIPE:1]            r_vld_pipe;
  logic [PIPE:1]            r_frm_pipe;
  logic [PIPE:1][DATA_W-1:0] r_dat_pipe;

  logic [EXT_W-1:0]  w_ext;
  logic [DATA_W-1:0] w_descr;
  logic [LFSR_W-1:0] w_h_nxt;
  logic [CNT_W-1:0]  w_fcnt_sum;
  logic [CNT_W-1:0]  w_fcnt_nxt;
  logic              w_trust;
  logic              w_vld_in;
  logic [DATA_W-1:0] w_data_in;

  // w_ext[LFSR_W + j] is the bit j positions after the current word's bit 0 (j may be negative)
  genvar g;
  generate
    for (g = 0; g < LFSR_W; g++) begin : g_hist
      assign w_ext[g]   = r_h[LFSR_W-1-g];
      assign w_h_nxt[g] = w_ext[EXT_W-1-g];
    end
    for (g = 0; g < DATA_W; g++) begin : g_bit
      assign w_ext[LFSR_W+g] = datain[g];
      assign w_descr[g]      = datain[g] ^ w_ext[g] ^ w_ext[g+LFSR_W-TAP];
    end
  endgenerate

  assign w_fcnt_sum = r_fcnt + CNT_W'(DATA_W);
  assign w_fcnt_nxt = (w_fcnt_sum >= CNT_W'(LFSR_W)) ? CNT_W'(LFSR_W) : w_fcnt_sum;
  assign w_trust    = (r_fcnt >= CNT_W'(LFSR_W));
  assign w_vld_in   = datain_valid & (bypass | (w_trust & ~resync));
  assign w_data_in  = bypass ? datain : w_descr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h     <= '0;
      r_fcnt  <= '0;
      r_state <= S_FILL;
    end else if (resync) begin
      r_h     <= '0;
      r_fcnt  <= '0;
      r_state <= S_FILL;
    end else if (datain_valid) begin
      r_h    <= w_h_nxt;
      r_fcnt <= w_fcnt_nxt;
      if (w_fcnt_nxt >= CNT_W'(LFSR_W)) r_state <= S_LOCKED;
    end
  end

  // Stage-1 data only loads on valid entries so dataout holds between valid words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_frm_pipe <= '0;
      r_dat_pipe <= '0;
    end else begin
      r_vld_pipe[1] <= w_vld_in;
      r_frm_pipe[1] <= framein;
      if (w_vld_in) r_dat_pipe[1] <= w_data_in;
      for (int s = 2; s <= PIPE; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        r_frm_pipe[s] <= r_frm_pipe[s-1];
        r_dat_pipe[s] <= r_dat_pipe[s-1];
      end
    end
  end

  assign dataout       = r_dat_pipe[PIPE];
  assign dataout_valid = r_vld_pipe[PIPE];
  assign frameout      = r_frm_pipe[PIPE];
  assign locked        = (r_state == S_LOCKED);

endmodule

// File: tb/tb_descrambler_par.sv
// Bench for descrambler_par: bit-serial scrambler source, bit-stream reference model with
// per-cycle output comparison, and hand-computed expectations for the directed scenarios.
module tb_descrambler_par;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [25:0] a_din, a_dout;
  logic        a_v, a_f, a_b, a_r, a_ov, a_of, a_lk;
  logic [63:0] b_din, b_dout;
  logic        b_v, b_f, b_b, b_r, b_ov, b_of, b_lk;

  descrambler_par u_a (
    .clk(clk), .rst(rst), .datain(a_din), .datain_valid(a_v), .framein(a_f),
    .bypass(a_b), .resync(a_r), .dataout(a_dout), .dataout_valid(a_ov),
    .frameout(a_of), .locked(a_lk));

  descrambler_par #(.DATA_W(64), .PIPE(3)) u_b (
    .clk(clk), .rst(rst), .datain(b_din), .datain_valid(b_v), .framein(b_f),
    .bypass(b_b), .resync(b_r), .dataout(b_dout), .dataout_valid(b_ov),
    .frameout(b_of), .locked(b_lk));

  always #5 clk = ~clk;

  typedef struct { int t; int u; bit v; logic [63:0] d; bit f; } ent_t;
  typedef struct { int t; int u; bit l; } lk_t;

  ent_t        eq[$];
  lk_t         lq[$];
  logic [63:0] got[$];
  logic [63:0] pl0[$];
  logic [63:0] pl1[$];
  int          ncyc = 0;
  int          npass = 0;
  int          ntot = 0;
  int          act = 0;
  bit          sb[2][16384];
  int          nb[2];
  bit          mlock[2];
  logic [63:0] last[2];
  logic [57:0] txs[2];

  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    ntot++;
    if (a === e) npass++;
    else $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, a, e, ncyc);
  endtask

  function automatic logic [63:0] obs_d(int u);
    return (u == 0) ? {38'b0, a_dout} : b_dout;
  endfunction
  function automatic logic obs_v(int u); return (u == 0) ? a_ov : b_ov; endfunction
  function automatic logic obs_f(int u); return (u == 0) ? a_of : b_of; endfunction
  function automatic logic obs_l(int u); return (u == 0) ? a_lk : b_lk; endfunction

  // Received-bit b(j) relative to the current word; bits before the last clear read as 0
  function automatic bit bv(int u, logic [63:0] d, int j);
    if (j >= 0) return d[j];
    if (nb[u] + j < 0) return 1'b0;
    return sb[u][nb[u]+j];
  endfunction

  // Bit-serial scrambler: s[n] = p[n] ^ s[n-39] ^ s[n-58]
  task automatic scr(int u, logic [63:0] p, output logic [63:0] s);
    int w = (u == 0) ? 26 : 64;
    s = '0;
    for (int i = 0; i < w; i++) begin
      s[i]   = p[i] ^ txs[u][38] ^ txs[u][57];
      txs[u] = {txs[u][56:0], s[i]};
    end
  endtask

  // Drive one cycle on unit u, and record what its outputs must show later
  task automatic step(int u, bit v, logic [63:0] din, bit f, bit byp, bit rs);
    int          w, p;
    logic [63:0] d, x, msk;
    bit          ev, trust;
    ent_t        e;
    lk_t         l;
    w   = (u == 0) ? 26 : 64;
    p   = (u == 0) ? 1 : 3;
    msk = (u == 0) ? 64'h3FF_FFFF : '1;
    d   = din & msk;
    a_v = 0; a_r = 0; a_f = 0; b_v = 0; b_r = 0; b_f = 0;
    if (u == 0) begin a_din = d[25:0]; a_v = v; a_f = f; a_b = byp; a_r = rs; end
    else        begin b_din = d;       b_v = v; b_f = f; b_b = byp; b_r = rs; end
    ev = 0;
    x  = d;
    if (rs) begin
      ev = v & byp;
      nb[u] = 0;
      mlock[u] = 0;
    end else if (v) begin
      trust = (nb[u] >= 58);
      for (int i = 0; i < w; i++) x[i] = d[i] ^ bv(u, d, i - 58) ^ bv(u, d, i - 39);
      for (int i = 0; i < w; i++) sb[u][nb[u]+i] = d[i];
      nb[u] += w;
      if (nb[u] >= 58) mlock[u] = 1;
      ev = byp | trust;
      if (byp) x = d;
    end
    if (ev) last[u] = x;
    e.t = ncyc + p; e.u = u; e.v = ev; e.d = last[u]; e.f = f;
    eq.push_back(e);
    l.t = ncyc + 1; l.u = u; l.l = mlock[u];
    lq.push_back(l);
    act = u;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int u, int n);
    repeat (n) step(u, 0, '0, 0, 0, 0);
  endtask

  task automatic rst_chk();
    chk("rst_dout_a", {38'b0, a_dout}, 64'd0);
    chk("rst_vld_a", a_ov, 0);
    chk("rst_frm_a", a_of, 0);
    chk("rst_lock_a", a_lk, 0);
    chk("rst_dout_b", b_dout, 64'd0);
    chk("rst_vld_b", b_ov, 0);
    chk("rst_frm_b", b_of, 0);
    chk("rst_lock_b", b_lk, 0);
  endtask

  // Assert reset between edges, check the asynchronous clear, then release after an edge
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 rst_chk();
    eq.delete(); lq.delete(); got.delete();
    for (int u = 0; u < 2; u++) begin
      nb[u] = 0; mlock[u] = 0; last[u] = '0; txs[u] = '0;
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic chk_got(input logic [63:0] pl[$], int off, int n);
    chk("out_word_count", got.size(), n);
    for (int i = 0; i < n; i++)
      if (i < got.size()) chk("out_word_plain", got[i], pl[off+i]);
  endtask

  always @(negedge clk) begin : cmp
    ent_t e;
    lk_t  l;
    while (eq.size() > 0 && eq[0].t <= ncyc) begin
      e = eq.pop_front();
      if (e.t == ncyc) begin
        chk("dataout_valid", obs_v(e.u), e.v);
        chk("dataout", obs_d(e.u), e.d);
        chk("frameout", obs_f(e.u), e.f);
      end
    end
    while (lq.size() > 0 && lq[0].t <= ncyc) begin
      l = lq.pop_front();
      if (l.t == ncyc) chk("locked", obs_l(l.u), l.l);
    end
    if (!rst && obs_v(act)) got.push_back(obs_d(act));
  end

  initial begin : stim
    logic [63:0] s;
    a_din = '0; a_v = 0; a_f = 0; a_b = 0; a_r = 0;
    b_din = '0; b_v = 0; b_f = 0; b_b = 0; b_r = 0;
    for (int u = 0; u < 2; u++) begin
      nb[u] = 0; mlock[u] = 0; last[u] = '0; txs[u] = '0;
    end
    #1 rst = 1'b1;
    #1 rst_chk();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Continuous scrambled stream: words 0-2 fill, 3.. must equal plaintext
    for (int k = 0; k < 15; k++) pl0.push_back({38'b0, 26'($urandom)});
    for (int k = 0; k < 10; k++) begin
      scr(0, pl0[k], s);
      step(0, 1, s, 0, 0, 0);
      if (k == 1) chk("lock_after_w1", a_lk, 0);
      if (k == 2) chk("lock_after_w2", a_lk, 1);
      if (k == 3) chk("w3_plain", {38'b0, a_dout}, pl0[3]);
    end
    idle(0, 3);
    chk_got(pl0, 3, 7);

    // Same stream with random valid gaps
    do_reset();
    got.delete();
    for (int k = 0; k < 10; k++) begin
      idle(0, $urandom_range(0, 2));
      scr(0, pl0[k], s);
      step(0, 1, s, 0, 0, 0);
    end
    idle(0, 3);
    chk_got(pl0, 3, 7);

    // Resync alongside a valid word while locked
    got.delete();
    scr(0, pl0[10], s);
    step(0, 1, s, 0, 0, 1);
    chk("lock_after_resync", a_lk, 0);
    for (int k = 11; k < 15; k++) begin
      scr(0, pl0[k], s);
      step(0, 1, s, 0, 0, 0);
    end
    idle(0, 3);
    chk_got(pl0, 14, 1);

    // Bypass from reset, then descramble the alternating pattern
    do_reset();
    step(0, 1, 64'h2AAAAAA, 0, 1, 0);
    chk("byp_dout", {38'b0, a_dout}, 64'h2AAAAAA);
    chk("byp_vld", a_ov, 1);
    chk("byp_lock", a_lk, 0);
    step(0, 1, 64'h2AAAAAA, 0, 1, 0);
    step(0, 1, 64'h2AAAAAA, 0, 1, 0);
    step(0, 1, 64'h2AAAAAA, 0, 0, 0);
    chk("post_byp_dout", {38'b0, a_dout}, 64'h1555555);
    chk("post_byp_vld", a_ov, 1);
    idle(0, 2);

    // 64-bit words, 3-stage pipe: one word fills, taps reach into the current word
    do_reset();
    got.delete();
    for (int k = 0; k < 4; k++) pl1.push_back({$urandom, $urandom});
    for (int k = 0; k < 4; k++) begin
      scr(1, pl1[k], s);
      step(1, 1, s, 0, 0, 0);
      if (k == 0) chk("w64_lock", b_lk, 1);
    end
    idle(1, 4);
    chk_got(pl1, 1, 3);

    // Mid-stream reset, then frame pulses through each pipe depth
    step(0, 1, 64'h3123456, 0, 1, 0);
    step(0, 1, 64'h0ABCDEF, 0, 1, 0);
    chk("pre_rst_vld", a_ov, 1);
    do_reset();
    step(0, 0, '0, 1, 0, 0);
    chk("frame_a_lat1", a_of, 1);
    step(0, 0, '0, 0, 0, 0);
    chk("frame_a_gone", a_of, 0);
    step(1, 0, '0, 1, 0, 0);
    step(1, 0, '0, 0, 0, 0);
    chk("frame_b_early", b_of, 0);
    step(1, 0, '0, 0, 0, 0);
    chk("frame_b_lat3", b_of, 1);
    idle(1, 3);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
